i2c_eeprom_master: RTL and testbench

Byte-level I2C master that performs single-byte random writes and random reads on a 24C64-class serial EEPROM: 8 KiB, 13-bit word address, 2-byte address phase. It sits between system logic, which issues a request with address and data, and the EEPROM's `scl`/`sda` pins. It generates START, repeated-START and STOP conditions, shifts bytes, checks slave ACKs and returns read data.

---
 rtl/i2c_eeprom_master.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_eeprom_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_master.sv
// I2C master for 24C64-class EEPROMs: single-byte random write and
// random read with a 13-bit word address and open-drain SDA.
module i2c_eeprom_master #(
    parameter int unsigned CLK_DIV  = 125,
    parameter logic [2:0]  DEV_ADDR = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [12:0] addr,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        scl,
    inout  wire         sda
);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, TX_BYTE, RX_ACK, RSTART,
        RX_BYTE, TX_NACK, STOP, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic          rd_op_q, rd_op_d;
    logic          rs_q, rs_d;
    logic          err_q, err_d;
    logic [12:0]   addr_q, addr_d;
    logic [7:0]    wdat_q, wdat_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          ack_err_q, ack_err_d;
    logic          scl_q, scl_d;
    logic          sda_low_q, sda_low_d;
    logic [1:0]    sda_sync_q;
    logic [7:0]    tx_byte;
    logic          sda_in, slot_end, idle, accept;

    assign sda_in   = sda_sync_q[1];
    assign slot_end = (div_q == DIV_LAST) && (phase_q == 2'd3);
    assign idle     = (state_q == IDLE) || (state_q == DONE);
    assign accept   = idle && (wr_req || rd_req);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        rd_op_d   = rd_op_q;
        rs_d      = rs_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rx_d      = rx_q;
        rd_data_d = rd_data_q;
        ack_err_d = ack_err_q;
        if (!idle) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (div_q == DIV_LAST) phase_d = phase_q + 2'd1;
        end
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d   = START;
                    div_d     = '0;
                    phase_d   = '0;
                    bit_d     = '0;
                    byte_d    = '0;
                    rd_op_d   = ~wr_req;
                    rs_d      = 1'b0;
                    err_d     = 1'b0;
                    ack_err_d = 1'b0;
                    addr_d    = addr;
                    wdat_d    = wr_data;
                end
            end
            START: if (slot_end) state_d = TX_BYTE;
            RSTART: if (slot_end) begin
                state_d = TX_BYTE;
                rs_d    = 1'b1;
                byte_d  = 2'd0;
            end
            TX_BYTE: if (slot_end) begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = RX_ACK;
            end
            RX_ACK: if (slot_end) begin
                if (sda_in) begin
                    err_d   = 1'b1;
                    state_d = STOP;
                end else if (rs_q) begin
                    state_d = RX_BYTE;
                end else if (rd_op_q && byte_q == 2'd2) begin
                    state_d = RSTART;
                end else if (byte_q == 2'd3) begin
                    state_d = STOP;
                end else begin
                    byte_d  = byte_q + 2'd1;
                    state_d = TX_BYTE;
                end
            end
            RX_BYTE: if (slot_end) begin
                rx_d  = {rx_q[6:0], sda_in};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = TX_NACK;
            end
            TX_NACK: if (slot_end) state_d = STOP;
            STOP: if (slot_end) begin
                state_d   = DONE;
                ack_err_d = err_q;
                if (rd_op_q && !err_q) rd_data_d = rx_q;
            end
            default: state_d = IDLE;
        endcase

        // Bus pins are registered from the next-state view so they
        // switch on the same edge as the slot/phase they belong to.
        unique case (byte_d)
            2'd0:    tx_byte = {4'b1010, DEV_ADDR, rs_d};
            2'd1:    tx_byte = {3'b000, addr_q[12:8]};
            2'd2:    tx_byte = addr_q[7:0];
            default: tx_byte = wdat_q;
        endcase
        scl_d     = 1'b1;
        sda_low_d = sda_low_q;
        unique case (state_d)
            START: sda_low_d = phase_d[1];
            RSTART: begin
                scl_d     = (phase_d != 2'd0);
                sda_low_d = phase_d[1];
            end
            TX_BYTE: begin
                scl_d = phase_d[1];
                if (phase_d != 2'd0) sda_low_d = ~tx_byte[~bit_d];
            end
            RX_ACK, RX_BYTE, TX_NACK: begin
                scl_d = phase_d[1];
                if (phase_d != 2'd0) sda_low_d = 1'b0;
            end
            STOP: begin
                scl_d     = phase_d[1];
                sda_low_d = (phase_d != 2'd3);
            end
            default: sda_low_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            phase_q    <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            rd_op_q    <= 1'b0;
            rs_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdat_q     <= '0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            ack_err_q  <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
            sda_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            rd_op_q    <= rd_op_d;
            rs_q       <= rs_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            ack_err_q  <= ack_err_d;
            scl_q      <= scl_d;
            sda_low_q  <= sda_low_d;
            sda_sync_q <= {sda_sync_q[0], sda};
        end
    end

    assign sda     = sda_low_q ? 1'b0 : 1'bz;
    assign scl     = scl_q;
    assign busy    = !idle;
    assign done    = (state_q == DONE);
    assign rd_data = rd_data_q;
    assign ack_err = ack_err_q;
endmodule

// File: tb/tb_i2c_eeprom_master.sv
// Randomised bench for i2c_eeprom_master with a behavioural
// 24C64 slave, expected-memory array and bus-event log.
module tb_i2c_eeprom_master;
    localparam int C = 4;
    localparam logic [2:0] DEV = 3'b000;
    localparam int BS = 256;
    localparam int BP = 257;
    localparam int BM = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req, rd_req;
    logic [12:0] addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        busy, done, ack_err, scl;
    wire         sda;

    i2c_eeprom_master #(.CLK_DIV(C), .DEV_ADDR(DEV)) dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .busy(busy), .done(done), .ack_err(ack_err),
        .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    logic s_low, s_rst, s_en;
    assign sda = s_low ? 1'b0 : 1'bz;
    pullup (sda);

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int bus_q[$];
    logic [7:0] smem [0:8191];
    logic [7:0] ref_mem [0:8191];
    logic [7:0] last_rd;

    // Behavioural slave: decodes START/STOP, receives bytes, ACKs,
    // serves read data and logs every bus event it sees.
    logic [2:0]  mode;
    logic        p_scl, p_sda, c_scl, c_sda, rdir, wpend, ack;
    logic [7:0]  sh, tx, wbyte;
    logic [12:0] ptr;
    int          cnt, tcnt, bi;
    always @(negedge clk) begin
        if (s_rst) begin
            mode = 0; s_low = 0; p_scl = 1; p_sda = 1;
            cnt = 0; tcnt = 0; bi = 0; wpend = 0; rdir = 0;
        end else begin
            c_scl = scl;
            c_sda = sda;
            if (p_scl && c_scl && p_sda && !c_sda) begin
                bus_q.push_back(BS);
                mode = 1; cnt = 0; bi = 0; rdir = 0;
            end else if (p_scl && c_scl && !p_sda && c_sda) begin
                bus_q.push_back(BP);
                if (wpend) smem[ptr] = wbyte;
                wpend = 0; mode = 0; s_low = 0;
            end else if (!p_scl && c_scl) begin
                if (mode == 1) begin
                    sh = {sh[6:0], c_sda}; cnt++;
                end else if (mode == 4) begin
                    bus_q.push_back(BM | int'(c_sda)); mode = 0;
                end
            end else if (p_scl && !c_scl) begin
                if (mode == 1 && cnt == 8) begin
                    bus_q.push_back(int'(sh));
                    ack = 0;
                    if (bi == 0) begin
                        if (sh[7:1] == {4'b1010, DEV}) begin
                            ack = 1; rdir = sh[0];
                        end
                    end else if (bi == 1) begin
                        ptr[12:8] = sh[4:0]; ack = 1;
                    end else if (bi == 2) begin
                        ptr[7:0] = sh; ack = 1;
                    end else if (bi == 3) begin
                        wbyte = sh; wpend = 1; ack = 1;
                    end
                    bi++;
                    if (ack && s_en) begin
                        s_low = 1; mode = 2;
                    end else mode = 0;
                end else if (mode == 2) begin
                    s_low = 0;
                    if (rdir) begin
                        tx = smem[ptr]; s_low = !tx[7];
                        tcnt = 1; mode = 3;
                    end else begin
                        mode = 1; cnt = 0;
                    end
                end else if (mode == 3) begin
                    if (tcnt == 8) begin
                        s_low = 0; mode = 4;
                    end else begin
                        s_low = !tx[7 - tcnt]; tcnt++;
                    end
                end
            end
            p_scl = c_scl;
            p_sda = c_sda;
        end
    end

    always @(posedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_op(input bit w, input bit r, input logic [12:0] a,
                         input logic [7:0] d, input bit poke);
        int n, slots, dc0, lim;
        int exp_q[$];
        bit is_wr, err;
        logic [7:0] cw, exp_rd;
        is_wr = w;
        err   = !s_en;
        cw    = {4'b1010, DEV, 1'b0};
        exp_q = {BS, int'(cw)};
        if (err) begin
            exp_q.push_back(BP);
            slots = 11;
        end else begin
            exp_q.push_back(int'({3'b000, a[12:8]}));
            exp_q.push_back(int'(a[7:0]));
            if (is_wr) begin
                exp_q.push_back(int'(d));
                exp_q.push_back(BP);
                slots = 38;
            end else begin
                exp_q.push_back(BS);
                exp_q.push_back(int'(cw | 8'h01));
                exp_q.push_back(BM | 1);
                exp_q.push_back(BP);
                slots = 48;
            end
        end
        exp_rd = (!is_wr && !err) ? ref_mem[a] : last_rd;
        bus_q.delete();
        dc0 = done_cnt;
        @(negedge clk);
        wr_req = w; rd_req = r; addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_req = 0; rd_req = 0;
        addr = 13'($urandom); wr_data = 8'($urandom);
        chk("busy_rise", busy, 1);
        n = 0;
        lim = 240 * C;
        while (!done && n < lim) begin
            @(posedge clk); #1;
            n++;
            if (poke) rd_req = (n == 50);
        end
        rd_req = 0;
        chk("latency", n, slots * 4 * C);
        chk("busy_at_done", busy, 0);
        chk("ack_err", ack_err, err);
        chk("rd_data", rd_data, exp_rd);
        chk("bus_len", bus_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < bus_q.size())
                chk($sformatf("bus[%0d]", i), bus_q[i], exp_q[i]);
        if (is_wr && !err) begin
            ref_mem[a] = d;
            chk("slave_mem", smem[a], d);
        end
        last_rd = exp_rd;
        repeat (20) @(posedge clk);
        #1;
        chk("one_done", done_cnt - dc0, 1);
        chk("idle_busy", busy, 0);
        chk("err_hold", ack_err, err);
    endtask

    initial begin
        logic [12:0] a;
        logic [7:0]  d;
        int dc0;
        for (int i = 0; i < 8192; i++) begin
            smem[i] = 8'hFF;
            ref_mem[i] = 8'hFF;
        end
        last_rd = 8'h00;
        rst_n = 0; s_rst = 1; s_en = 1;
        wr_req = 0; rd_req = 0; addr = 0; wr_data = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", ack_err, 0);
        chk("rst_rd", rd_data, 0);
        @(negedge clk);
        rst_n = 1; s_rst = 0;
        repeat (5) @(posedge clk);

        do_op(1, 0, 13'h1ABC, 8'h5A, 0);
        do_op(0, 1, 13'h1ABC, 8'h00, 0);
        do_op(1, 0, 13'h1FFF, 8'hFF, 0);
        do_op(1, 0, 13'h0000, 8'h01, 0);
        do_op(0, 1, 13'h1FFF, 8'h00, 0);
        do_op(0, 1, 13'h0000, 8'h00, 0);

        s_en = 0;
        do_op(1, 0, 13'h0123, 8'h77, 0);
        s_en = 1;

        do_op(1, 1, 13'h0456, 8'hC3, 1);
        do_op(0, 1, 13'h0456, 8'h00, 0);

        bus_q.delete();
        dc0 = done_cnt;
        @(negedge clk);
        wr_req = 1; addr = 13'h0321; wr_data = 8'h99;
        @(posedge clk); #1;
        wr_req = 0;
        repeat (48 * C) @(posedge clk);
        #1;
        rst_n = 0; s_rst = 1;
        @(posedge clk); #1;
        chk("mid_rst_scl", scl, 1);
        chk("mid_rst_sda", sda, 1);
        chk("mid_rst_busy", busy, 0);
        rst_n = 1;
        @(negedge clk);
        s_rst = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_nodone", done_cnt - dc0, 0);
        last_rd = 8'h00;
        do_op(1, 0, 13'h0010, 8'($urandom), 0);
        do_op(0, 1, 13'h0010, 8'h00, 0);

        for (int k = 0; k < 16; k++) begin
            a = 13'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) a = a | 13'h1FF8;
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_op(1, 0, a, d, 0);
            else do_op(0, 1, a, d, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
